// File: rtl/step_count_pkg.sv
// Shared types and helpers for the step counter scheduler.
// Holds the FSM state encoding and flattened-bus slice extraction.
package step_count_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_LENW  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RUN,
    ST_DONE
  } state_e;

  // Slice idx of a flattened bus with w-bit fields, w < 32.
  function automatic logic [31:0] get_slice(
    input logic [255:0] bus,
    input int           idx,
    input int           w
  );
    logic [255:0] sh;
    sh = bus >> (idx * w);
    return sh[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/step_count_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches upward from the slot after rr_ptr, wrapping modulo NREQ.
module rr_arbiter
  import step_count_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] win,
  output logic [IDW-1:0]  win_id,
  output logic            valid
);

  int   idx;
  logic found;

  always_comb begin
    win    = '0;
    win_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_id   = IDW'(idx);
      end
    end
    valid = found;
  end

endmodule

// File: rtl/step_count_sched.sv
// Round-robin scheduler driving a shared programmable-step counter.
// Grants one requester, runs its latched command, reports the result.
module step_count_sched
  import step_count_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEF_WIDTH,
  parameter int LENW  = DEF_LENW,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] step_in,
  input  logic [NREQ*LENW-1:0]  len_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic                  cnt_vld,
  output logic                  done,
  output logic [IDW-1:0]        done_id
);

  localparam logic [LENW-1:0] ONE_L = LENW'(1);
  localparam logic [IDW-1:0]  PTR_RST = IDW'(NREQ - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [LENW-1:0]  len_q, len_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [LENW-1:0]  sl_q, sl_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             cnt_vld_q, cnt_vld_d;
  logic             done_q, done_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NREQ-1:0]  arb_win;
  logic [IDW-1:0]   arb_id;
  logic             arb_valid;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .win    (arb_win),
    .win_id (arb_id),
    .valid  (arb_valid)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    len_d     = len_q;
    id_d      = id_q;
    sl_d      = sl_q;
    count_d   = count_q;
    cnt_vld_d = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    gnt_d     = '0;
    busy_d    = busy_q;
    rr_ptr_d  = rr_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_GRANT;
          gnt_d   = arb_win;
          busy_d  = 1'b1;
          step_d  = WIDTH'(get_slice(256'(step_in), int'(arb_id), WIDTH));
          len_d   = LENW'(get_slice(256'(len_in), int'(arb_id), LENW));
          id_d    = arb_id;
          count_d = '0;
        end
      end
      ST_GRANT: begin
        if (len_q == '0) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          done_id_d = id_q;
        end else begin
          // First step lands here so its result shows in the first RUN cycle.
          state_d   = ST_RUN;
          count_d   = count_q + step_q;
          cnt_vld_d = 1'b1;
          sl_d      = len_q - ONE_L;
        end
      end
      ST_RUN: begin
        if (sl_q == '0) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          done_id_d = id_q;
        end else begin
          count_d   = count_q + step_q;
          cnt_vld_d = 1'b1;
          sl_d      = sl_q - ONE_L;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        rr_ptr_d = id_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
      sl_q      <= '0;
      count_q   <= '0;
      cnt_vld_q <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      rr_ptr_q  <= PTR_RST;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      len_q     <= len_d;
      id_q      <= id_d;
      sl_q      <= sl_d;
      count_q   <= count_d;
      cnt_vld_q <= cnt_vld_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign count   = count_q;
  assign cnt_vld = cnt_vld_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule
